commit_arbiter: RTL and testbench

- Merges the commit streams of the execute units (ALU, LSU, CSR, MUL/DIV, FPU) into one writeback stream for the register file and scoreboard.
- Sits directly downstream of each unit's commit output register.
- Uses a round-robin arbiter with eop-based grant locking, so multi-beat responses stay contiguous.
- Has one registered output stage with full-throughput backpressure.

---
 rtl/commit_arbiter_pkg.sv | 21 ++
 rtl/commit_rr_arbiter.sv | 48 ++++
 rtl/commit_arbiter.sv | 75 +++++++
 tb/tb_commit_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/commit_arbiter_pkg.sv
// commit_arbiter_pkg: shared constants and commit beat type for the commit arbiter
package commit_arbiter_pkg;
    localparam int DEF_NUM_REQS    = 5;
    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_NW_BITS     = 2;
    localparam int DEF_NR_BITS     = 5;
    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_CSR = 2;
    localparam int SRC_MUL = 3;
    localparam int SRC_FPU = 4;
    typedef struct packed {
        logic [DEF_NW_BITS-1:0]        wid;
        logic [DEF_NUM_THREADS-1:0]    tmask;
        logic [31:0]                   pc;
        logic [DEF_NR_BITS-1:0]        rd;
        logic                          wb;
        logic                          eop;
        logic [DEF_NUM_THREADS*32-1:0] data;
    } commit_beat_t;
endpackage

// File: rtl/commit_rr_arbiter.sv
// commit_rr_arbiter: round-robin grant with eop-based locking
// Ports: clk/reset; requests (valid per source); accept (beat taken this cycle) with
// accept_eop (taken beat ends its instruction); grant (one-hot or zero) and grant_idx.
module commit_rr_arbiter import commit_arbiter_pkg::*; #(
    parameter int NUM_REQS = DEF_NUM_REQS,
    parameter int IDX_W    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                accept,
    input  logic                accept_eop,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx
);
    logic [IDX_W-1:0] rr_ptr, lock_idx, idx;
    logic lock, found;
    // Scan from the farthest candidate down so the nearest one after rr_ptr wins.
    always_comb begin
        found = 1'b0;
        grant_idx = '0;
        idx = '0;
        if (lock) begin
            found = requests[lock_idx];
            grant_idx = lock_idx;
        end else begin
            for (int k = NUM_REQS; k >= 1; k--) begin
                idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQS);
                if (requests[idx]) begin
                    found = 1'b1;
                    grant_idx = idx;
                end
            end
        end
        grant = found ? NUM_REQS'(1) << grant_idx : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= IDX_W'(NUM_REQS - 1);
            lock <= 1'b0;
            lock_idx <= '0;
        end else if (accept) begin
            lock <= !accept_eop;
            if (accept_eop) rr_ptr <= grant_idx;
            else lock_idx <= grant_idx;
        end
    end
endmodule

// File: rtl/commit_arbiter.sv
// commit_arbiter: merges per-unit commit streams into one registered writeback stream
// Ports: clk/reset; per-source flat buses valid_in/ready_in/wid_in/tmask_in/PC_in/rd_in/
// wb_in/eop_in/data_in (source i at slice i); registered output beat valid_out/ready_out
// plus wid_out/tmask_out/PC_out/rd_out/wb_out/eop_out/data_out and sel_out (source index).
module commit_arbiter import commit_arbiter_pkg::*; #(
    parameter int NUM_REQS    = DEF_NUM_REQS,
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int NW_BITS     = DEF_NW_BITS,
    parameter int NR_BITS     = DEF_NR_BITS,
    localparam int SEL_W      = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQS-1:0]             valid_in,
    output logic [NUM_REQS-1:0]             ready_in,
    input  logic [NUM_REQS*NW_BITS-1:0]     wid_in,
    input  logic [NUM_REQS*NUM_THREADS-1:0] tmask_in,
    input  logic [NUM_REQS*32-1:0]          PC_in,
    input  logic [NUM_REQS*NR_BITS-1:0]     rd_in,
    input  logic [NUM_REQS-1:0]             wb_in,
    input  logic [NUM_REQS-1:0]             eop_in,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0] data_in,
    output logic                            valid_out,
    input  logic                            ready_out,
    output logic [NW_BITS-1:0]              wid_out,
    output logic [NUM_THREADS-1:0]          tmask_out,
    output logic [31:0]                     PC_out,
    output logic [NR_BITS-1:0]              rd_out,
    output logic                            wb_out,
    output logic                            eop_out,
    output logic [NUM_THREADS*32-1:0]       data_out,
    output logic [SEL_W-1:0]                sel_out
);
    localparam int DW = NUM_THREADS * 32;
    logic stall, accept;
    logic [NUM_REQS-1:0] grant;
    logic [SEL_W-1:0] gi;
    assign stall = valid_out && !ready_out;
    assign ready_in = (reset || stall) ? '0 : grant;
    assign accept = |ready_in;
    commit_rr_arbiter #(.NUM_REQS(NUM_REQS), .IDX_W(SEL_W)) u_arb (
        .clk(clk),
        .reset(reset),
        .requests(valid_in),
        .accept(accept),
        .accept_eop(eop_in[gi]),
        .grant(grant),
        .grant_idx(gi)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            wid_out <= '0;
            tmask_out <= '0;
            PC_out <= '0;
            rd_out <= '0;
            wb_out <= 1'b0;
            eop_out <= 1'b0;
            data_out <= '0;
            sel_out <= '0;
        end else if (!stall) begin
            valid_out <= accept;
            if (accept) begin
                wid_out <= wid_in[gi*NW_BITS +: NW_BITS];
                tmask_out <= tmask_in[gi*NUM_THREADS +: NUM_THREADS];
                PC_out <= PC_in[gi*32 +: 32];
                rd_out <= rd_in[gi*NR_BITS +: NR_BITS];
                wb_out <= wb_in[gi];
                eop_out <= eop_in[gi];
                data_out <= data_in[gi*DW +: DW];
                sel_out <= gi;
            end
        end
    end
endmodule

// File: tb/tb_commit_arbiter.sv
// tb_commit_arbiter: directed vector table, corner sequences and a scoreboarded random run
module tb_commit_arbiter;
    import commit_arbiter_pkg::*;
    localparam int N = 5, T = 4, NW = 2, NR = 5, SW = 3;
    logic clk = 1'b0, reset;
    logic [N-1:0] valid_in, ready_in, wb_in, eop_in;
    logic [N*NW-1:0] wid_in;
    logic [N*T-1:0] tmask_in;
    logic [N*32-1:0] PC_in;
    logic [N*NR-1:0] rd_in;
    logic [N*T*32-1:0] data_in;
    logic valid_out, ready_out, wb_out, eop_out;
    logic [NW-1:0] wid_out;
    logic [T-1:0] tmask_out;
    logic [31:0] PC_out;
    logic [NR-1:0] rd_out;
    logic [T*32-1:0] data_out;
    logic [SW-1:0] sel_out;
    logic [NW-1:0] wid_a[N];
    logic [T-1:0] tm_a[N];
    logic [31:0] pc_a[N];
    logic [NR-1:0] rd_a[N];
    logic [T*32-1:0] data_a[N];
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign wid_in[g*NW +: NW] = wid_a[g];
        assign tmask_in[g*T +: T] = tm_a[g];
        assign PC_in[g*32 +: 32] = pc_a[g];
        assign rd_in[g*NR +: NR] = rd_a[g];
        assign data_in[g*T*32 +: T*32] = data_a[g];
    end
    commit_arbiter #(.NUM_REQS(N), .NUM_THREADS(T), .NW_BITS(NW), .NR_BITS(NR)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .wid_in(wid_in), .tmask_in(tmask_in), .PC_in(PC_in), .rd_in(rd_in),
        .wb_in(wb_in), .eop_in(eop_in), .data_in(data_in),
        .valid_out(valid_out), .ready_out(ready_out), .wid_out(wid_out),
        .tmask_out(tmask_out), .PC_out(PC_out), .rd_out(rd_out), .wb_out(wb_out),
        .eop_out(eop_out), .data_out(data_out), .sel_out(sel_out)
    );
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    typedef struct {
        logic [N-1:0] v, e;
        logic r;
        logic [N-1:0] rdy;
        logic ov;
        int sel;
    } vec_t;
    vec_t tbl[15];
    int q_src[$];
    logic [31:0] q_pc[$];
    logic q_eop[$];
    int seq[N], exp_seq[N];
    int last_src = -1;
    logic last_eop = 1'b1;
    logic [N-1:0] acc;
    task automatic retire_check();
        int s;
        if (valid_out && ready_out) begin
            check("rnd_qnonempty", q_src.size() != 0, 1);
            if (q_src.size() != 0) begin
                s = q_src.pop_front();
                check("rnd_sel", sel_out, s);
                check("rnd_pc", PC_out, q_pc.pop_front());
                check("rnd_eop", eop_out, q_eop.pop_front());
                check("rnd_order", PC_out[23:0], exp_seq[s]);
                exp_seq[s]++;
                if (!last_eop) check("rnd_group", sel_out, last_src);
                last_src = int'(sel_out);
                last_eop = eop_out;
            end
        end
    endtask
    initial begin
        for (int i = 0; i < N; i++) begin
            wid_a[i] = NW'(i);
            tm_a[i] = T'(i + 1);
            pc_a[i] = 32'h1000_0000 + 32'(i);
            rd_a[i] = NR'(i + 1);
            data_a[i] = {T{32'(i) * 32'h0101_0101}};
        end
        tbl[0]  = '{5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 0};
        tbl[1]  = '{5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 1};
        tbl[2]  = '{5'b11111, 5'b11111, 1'b1, 5'b00100, 1'b1, 2};
        tbl[3]  = '{5'b11111, 5'b11111, 1'b1, 5'b01000, 1'b1, 3};
        tbl[4]  = '{5'b11111, 5'b11111, 1'b1, 5'b10000, 1'b1, 4};
        tbl[5]  = '{5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 0};
        tbl[6]  = '{5'b00000, 5'b11111, 1'b1, 5'b00000, 1'b0, 0};
        tbl[7]  = '{5'b00110, 5'b11101, 1'b1, 5'b00010, 1'b1, 1};
        tbl[8]  = '{5'b00110, 5'b11101, 1'b1, 5'b00010, 1'b1, 1};
        tbl[9]  = '{5'b00100, 5'b11111, 1'b1, 5'b00000, 1'b0, 0};
        tbl[10] = '{5'b00110, 5'b11111, 1'b1, 5'b00010, 1'b1, 1};
        tbl[11] = '{5'b00100, 5'b11111, 1'b1, 5'b00100, 1'b1, 2};
        tbl[12] = '{5'b01000, 5'b11111, 1'b0, 5'b00000, 1'b1, 2};
        tbl[13] = '{5'b01000, 5'b11111, 1'b1, 5'b01000, 1'b1, 3};
        tbl[14] = '{5'b00000, 5'b11111, 1'b1, 5'b00000, 1'b0, 0};
        reset = 1'b1;
        valid_in = '1;
        eop_in = '1;
        wb_in = '1;
        ready_out = 1'b1;
        repeat (2) begin
            #1 check("rst_ready", ready_in, 0);
            @(posedge clk);
            #1 check("rst_valid", valid_out, 0);
        end
        check("rst_sel", sel_out, 0);
        check("rst_pc", PC_out, 0);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            valid_in = tbl[k].v;
            eop_in = tbl[k].e;
            ready_out = tbl[k].r;
            #1 check($sformatf("vec%0d_ready", k), ready_in, tbl[k].rdy);
            @(posedge clk);
            #1 check($sformatf("vec%0d_valid", k), valid_out, tbl[k].ov);
            if (tbl[k].ov) begin
                check($sformatf("vec%0d_sel", k), sel_out, tbl[k].sel);
                check($sformatf("vec%0d_pc", k), PC_out, pc_a[tbl[k].sel]);
                check($sformatf("vec%0d_wid", k), wid_out, wid_a[tbl[k].sel]);
                check($sformatf("vec%0d_eop", k), eop_out, tbl[k].e[tbl[k].sel]);
            end
        end
        pc_a[0] = 32'h8000_0010;
        valid_in = 5'b00001;
        ready_out = 1'b1;
        #1 check("bp_accept", ready_in, 5'b00001);
        @(posedge clk);
        #1 check("bp_pc0", PC_out, 32'h8000_0010);
        valid_in = 5'b00010;
        ready_out = 1'b0;
        repeat (4) begin
            #1 check("bp_ready", ready_in, 0);
            @(posedge clk);
            #1 check("bp_valid", valid_out, 1);
            check("bp_pc", PC_out, 32'h8000_0010);
            check("bp_sel", sel_out, 0);
        end
        ready_out = 1'b1;
        #1 check("bp_release", ready_in, 5'b00010);
        @(posedge clk);
        #1 check("bp_next_valid", valid_out, 1);
        check("bp_next_sel", sel_out, 1);
        check("bp_next_pc", PC_out, pc_a[1]);
        valid_in = '0;
        @(posedge clk);
        #1 check("bp_drain", valid_out, 0);
        wb_in[3] = 1'b0;
        rd_a[3] = 5'd7;
        data_a[3] = {T{32'hDEAD_BEEF}};
        tm_a[3] = 4'b1010;
        valid_in = 5'b01000;
        #1 check("pt_ready", ready_in, 5'b01000);
        @(posedge clk);
        #1 check("pt_valid", valid_out, 1);
        check("pt_sel", sel_out, 3);
        check("pt_wb", wb_out, 0);
        check("pt_rd", rd_out, 7);
        check("pt_data", data_out, {T{32'hDEAD_BEEF}});
        check("pt_tmask", tmask_out, 4'b1010);
        check("pt_wid", wid_out, 2'd3);
        wb_in = '1;
        valid_in = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            exp_seq[i] = 0;
        end
        acc = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) seq[i]++;
                if (!valid_in[i] || acc[i]) begin
                    valid_in[i] = ($urandom_range(0, 1) == 1);
                    eop_in[i] = ($urandom_range(0, 2) == 0);
                    pc_a[i] = (32'(i) << 24) | 32'(seq[i]);
                end
            end
            ready_out = ($urandom_range(0, 3) != 0);
            #1;
            acc = valid_in & ready_in;
            check("rnd_grant", $onehot0(ready_in) && ((ready_in & ~valid_in) == 0), 1);
            retire_check();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    q_src.push_back(i);
                    q_pc.push_back(pc_a[i]);
                    q_eop.push_back(eop_in[i]);
                end
            end
            @(posedge clk);
            #1;
        end
        valid_in = '0;
        ready_out = 1'b1;
        repeat (3) begin
            #1 retire_check();
            @(posedge clk);
            #1;
        end
        check("rnd_drain", q_src.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
